lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRUP, default 1000000: cycles of power-up wait after reset release (20 ms at 50 MHz).
REQ-002 Parameter T_EN, default 16: cycles lcd_en is held high per write; legal values >= 1.
REQ-003 Parameter T_CMD, default 2000: post-pulse wait cycles for normal commands and data (40 us); legal values >= 1.
REQ-004 Parameter T_CLR, default 82000: post-pulse wait cycles for clear/home commands (1.64 ms); legal values >= 1.
REQ-005 clk  in  1  single clock for all logic, 50 MHz board clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  requester has a byte to write.
REQ-008 cmd_rs  in  1  0 = instruction, 1 = character data.
REQ-009 cmd_data  in  8  byte to write.
REQ-010 cmd_ready  out  1  controller accepts the byte this cycle.
REQ-011 init_done  out  1  power-up initialisation is complete.
REQ-012 lcd_data  out  8  LCD data bus (write-only; the top level drives the inout pad from this output).
REQ-013 lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon  out  1 each  LCD control pins.

Function
REQ-014 The block SHALL register all outputs; lcd_rw SHALL be constant 0; lcd_on and lcd_blon SHALL be 1 whenever reset is low.
REQ-015 State machine: PWRUP -> INIT (5 writes) -> IDLE; every write runs SETUP (1 cycle) -> PULSE (T_EN cycles) -> WAIT (T_CMD or T_CLR cycles) -> next state.
REQ-016 PWRUP SHALL last exactly T_PWRUP cycles after reset deasserts, with lcd_en = 0.
REQ-017 INIT SHALL write instruction bytes 0x38, 0x38, 0x0C, 0x01, 0x06 in that order with lcd_rs = 0.
REQ-018 The wait after a write SHALL be T_CLR when rs = 0 and data is 0x01, 0x02 or 0x03; otherwise it SHALL be T_CMD.
REQ-019 init_done and cmd_ready SHALL rise together in the first IDLE cycle; init_done then stays high until reset.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-021 cmd_valid SHALL be ignored during PWRUP and INIT, with no buffering.
REQ-022 On acceptance, cmd_rs and cmd_data SHALL be captured onto lcd_rs and lcd_data; both SHALL hold stable through SETUP, PULSE and WAIT, and later input changes SHALL have no effect.
REQ-023 Timing for a transfer accepted in cycle k:
- SETUP in cycle k+1 with lcd_en = 0;
- lcd_en = 1 in cycles k+2 .. k+1+T_EN;
- cmd_ready = 1 again in cycle k+2+T_EN+Twait.
REQ-024 Back-to-back throughput SHALL be one write per 2+T_EN+Twait cycles, with no idle cycle beyond that when cmd_valid is held.
REQ-025 Internal cycle counters SHALL be at least 20 bits wide and SHALL NOT wrap within any wait.

Reset
REQ-026 While reset is high:
- lcd_en, lcd_rs, lcd_data, cmd_ready and init_done SHALL be 0;
- the FSM SHALL be in PWRUP and the counters cleared.
REQ-027 Reset asserted mid-write SHALL force lcd_en low asynchronously, abort the write, and restart the full init sequence after release.

Verification (T_PWRUP=10, T_EN=2, T_CMD=5, T_CLR=20)
REQ-028 Release reset -> lcd_en low for 10 cycles, then pulses carrying 0x38, 0x38, 0x0C, 0x01, 0x06 with rs = 0, spaced 9, 9, 9, 24 cycles; init_done = 1 nine cycles after the last pulse starts.
REQ-029 After init, send cmd_rs=1 and cmd_data=0x41 -> lcd_en high for 2 cycles starting 2 cycles after acceptance; lcd_data = 0x41 and lcd_rs = 1 stable throughout; cmd_ready returns 9 cycles after acceptance.
REQ-030 Hold cmd_valid with 3 queued bytes -> acceptances spaced exactly 9 cycles; bytes appear in order.
REQ-031 Send command 0x02 -> cmd_ready returns 24 cycles after acceptance; command 0x04 -> 9 cycles.
REQ-032 Assert reset during PULSE -> lcd_en drops the same cycle, with no clock edge required; after release, the full init sequence from REQ-028 repeats.
REQ-033 Hold cmd_valid=1 with data 0xAA from reset release -> no 0xAA write during init; 0xAA is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/lcd_ctrl.sv
// Character-LCD write controller: power-up delay, fixed five-byte init sequence,
// then one-byte-at-a-time writes from a valid/ready requester with per-command settle times.
module lcd_ctrl #(
  parameter int unsigned T_PWRUP = 1000000,
  parameter int unsigned T_EN    = 16,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int unsigned T_MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned T_MAX_B = (T_EN > T_CMD) ? T_EN : T_CMD;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = ($clog2(T_MAX + 1) > 20) ? $clog2(T_MAX + 1) : 20;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLR - 1);
  localparam logic [2:0]       INIT_LEN   = 3'd5;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_IDLE
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h38;
      3'd2:    init_byte = 8'h0C;
      3'd3:    init_byte = 8'h01;
      3'd4:    init_byte = 8'h06;
      default: init_byte = 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_en_q, lcd_en_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             init_done_q, init_done_d;
  logic             is_clr;
  logic [CNT_W-1:0] wait_last;

  // Clear/home instructions need the long settle time; everything else the short one.
  always_comb begin
    is_clr    = !lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});
    wait_last = is_clr ? CLR_LAST : CMD_LAST;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        if (idx_q != INIT_LEN) begin
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_byte(idx_q);
          idx_d      = idx_q + 3'd1;
          state_d    = S_SETUP;
        end else if (cnt_q == '0) begin
          // Hand-over slot: init_done lands one full write period after the last pulse.
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          state_d = init_done_q ? S_IDLE : S_INIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          lcd_rs_d   = cmd_rs;
          lcd_data_d = cmd_data;
          state_d    = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    lcd_en_d    = (state_d == S_PULSE);
    cmd_ready_d = (state_d == S_IDLE);
    init_done_d = init_done_q | cmd_ready_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      cmd_ready_q <= cmd_ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;
  assign lcd_data  = lcd_data_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_en    = lcd_en_q;
  // Write-only bus; panel and backlight stay powered.
  assign lcd_rw    = 1'b0;
  assign lcd_on    = 1'b1;
  assign lcd_blon  = 1'b1;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed init/command/reset steps plus random traffic,
// checked cycle by cycle against a write-slot timing model.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 10;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .T_PWRUP(T_PWRUP),
    .T_EN   (T_EN),
    .T_CMD  (T_CMD),
    .T_CLR  (T_CLR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .init_done(init_done),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_rw   (lcd_rw),
    .lcd_on   (lcd_on),
    .lcd_blon (lcd_blon)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle 0 is the cycle in which reset drops.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         start;
    int         fin;
    logic       rs;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_w[$];
  int   rises[$];
  int   exp_free;
  int   init_idle;
  int   first_rdy;
  logic prev_en;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int t_wait(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_CMD;
  endfunction

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 4));
    return 8'($urandom());
  endfunction

  // Each write owns a slot of 2+T_EN+wait cycles: issue, setup, pulse, settle.
  task automatic model_init();
    logic [7:0] rom [5];
    wr_t        w;
    int         s;
    rom = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    exp_w.delete();
    rises.delete();
    first_rdy = -1;
    prev_en   = 1'b0;
    s = T_PWRUP + 2;
    for (int i = 0; i < 5; i++) begin
      w.start = s;
      w.fin   = s + T_EN + t_wait(1'b0, rom[i]);
      w.rs    = 1'b0;
      w.data  = rom[i];
      exp_w.push_back(w);
      s = s + 2 + T_EN + t_wait(1'b0, rom[i]);
    end
    init_idle = s;
    exp_free  = s;
  endtask

  task automatic cycle_step(input logic v, input logic rs, input logic [7:0] d,
                            output logic acc, output logic rdy, output int c);
    logic en_exp;
    wr_t  w;
    @(negedge clk);
    c   = cyc;
    rdy = cmd_ready;
    check("cmd_ready", cmd_ready, c >= exp_free);
    check("init_done", init_done, c >= init_idle);
    en_exp = 1'b0;
    foreach (exp_w[i]) begin
      if (c >= exp_w[i].start && c < exp_w[i].start + T_EN) en_exp = 1'b1;
      if (c >= exp_w[i].start - 1 && c < exp_w[i].fin) begin
        check("lcd_data", lcd_data, exp_w[i].data);
        check("lcd_rs", lcd_rs, exp_w[i].rs);
      end
    end
    check("lcd_en", lcd_en, en_exp);
    check("lcd_rw", lcd_rw, 1'b0);
    check("lcd_on", lcd_on, 1'b1);
    check("lcd_blon", lcd_blon, 1'b1);
    if (lcd_en && !prev_en) rises.push_back(c);
    prev_en = lcd_en;
    if (rdy && first_rdy < 0) first_rdy = c;
    cmd_valid = v;
    cmd_rs    = rs;
    cmd_data  = d;
    acc = v && (c >= exp_free);
    if (acc) begin
      w.start = c + 2;
      w.fin   = c + 2 + T_EN + t_wait(rs, d);
      w.rs    = rs;
      w.data  = d;
      exp_w.push_back(w);
      exp_free = w.fin;
    end
  endtask

  task automatic check_init_shape();
    check("init_pulse_count", rises.size() >= 5, 1'b1);
    if (rises.size() >= 5) begin
      check("init_gap_0", rises[1] - rises[0], 9);
      check("init_gap_1", rises[2] - rises[1], 9);
      check("init_gap_2", rises[3] - rises[2], 9);
      check("init_gap_3", rises[4] - rises[3], 24);
      check("init_done_delay", first_rdy - rises[4], 9);
    end
  endtask

  task automatic send_one(input logic rs, input logic [7:0] d, input int exp_gap, input string tag);
    logic acc, rdy;
    int   c, k, n;
    rdy = 1'b0;
    n   = 0;
    c   = 0;
    while (!rdy && n < 300) begin
      cycle_step(1'b1, rs, d, acc, rdy, c);
      n++;
    end
    k   = c;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 300) begin
      cycle_step(1'b0, rs, d, acc, rdy, c);
      n++;
    end
    check(tag, c - k, exp_gap);
  endtask

  task automatic random_run(input int n);
    logic acc, rdy;
    int   c;
    for (int i = 0; i < n; i++)
      cycle_step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_byte(), acc, rdy, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc, rdy;
    int         c, n, idx;
    logic [7:0] burst [3];
    int         acc_c[$];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_en", lcd_en, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);

    // Requester presents 0xAA from reset release: must wait out the whole init.
    model_init();
    @(posedge clk);
    #1 reset = 1'b0;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 300) begin
      cycle_step(1'b1, 1'b1, 8'hAA, acc, rdy, c);
      n++;
    end
    check("init_ready_seen", rdy, 1'b1);
    check_init_shape();

    send_one(1'b1, 8'h41, 9, "gap_data_41");

    burst = '{8'h48, 8'h49, 8'h4A};
    idx = 0;
    n   = 0;
    while (idx < 3 && n < 300) begin
      cycle_step(1'b1, 1'b1, burst[idx], acc, rdy, c);
      if (rdy) begin
        acc_c.push_back(c);
        idx++;
      end
      n++;
    end
    check("burst_accepts", acc_c.size(), 3);
    if (acc_c.size() == 3) begin
      check("burst_gap_0", acc_c[1] - acc_c[0], 9);
      check("burst_gap_1", acc_c[2] - acc_c[1], 9);
    end

    send_one(1'b0, 8'h02, 24, "gap_cmd_02");
    send_one(1'b0, 8'h04, 9, "gap_cmd_04");
    send_one(1'b1, 8'h03, 9, "gap_data_03");
    send_one(1'b0, 8'h01, 24, "gap_cmd_01");

    random_run(400);

    // Start a write, then hit reset while lcd_en is high.
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 300) begin
      cycle_step(1'b1, 1'b1, 8'h55, acc, rdy, c);
      n++;
    end
    n = 0;
    while (!lcd_en && n < 20) begin
      cycle_step(1'b0, 1'b1, 8'h55, acc, rdy, c);
      n++;
    end
    check("pulse_before_reset", lcd_en, 1'b1);
    #1 reset = 1'b1;
    #2;
    check("async_en_drop", lcd_en, 1'b0);
    check("async_ready_drop", cmd_ready, 1'b0);
    check("async_done_drop", init_done, 1'b0);
    check("async_data_clear", lcd_data, 8'h00);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_init();
    #1 reset = 1'b0;

    random_run(500);
    check_init_shape();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
